lif_tdm_scheduler: RTL and testbench

//  Time-multiplexes one LIF membrane-update datapath across N_NEURONS virtual neurons.

---
 rtl/lif_pkg.sv | 17 +
 rtl/lif_update_core.sv | 38 +++
 rtl/lif_tdm_scheduler.sv | 101 ++++++++++
 tb/tb_lif_tdm_scheduler.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// lif_pkg: shared defaults, datapath typedefs and FSM encoding for the LIF scheduler
package lif_pkg;
   localparam int LIF_N_NEURONS    = 16;
   localparam int LIF_I_WIDTH      = 8;
   localparam int LIF_I_FRAC_WIDTH = 4;
   localparam int LIF_WIDTH        = 16;
   localparam int LIF_FRAC_WIDTH   = 8;
   localparam int LIF_A_OPT        = 232;
   localparam int LIF_B_OPT        = 256;
   localparam int LIF_V_RESET      = -20480;
   typedef logic signed [LIF_WIDTH-1:0]     state_t;
   typedef logic signed [2*LIF_WIDTH-1:0]   mult_t;
   typedef logic signed [2*LIF_WIDTH+1:0]   accum_t;
   localparam int MAX_VAL = (2 ** (LIF_WIDTH - 1)) - 1;
   localparam int MIN_VAL = -MAX_VAL - 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
endpackage

// File: rtl/lif_update_core.sv
// lif_update_core: combinational LIF membrane update (v, cur) -> (v_next, spk)
//  v      in   WIDTH     current membrane value, signed Q.FRAC_WIDTH
//  cur    in   I_WIDTH   input current, signed Q.I_FRAC_WIDTH
//  v_next out  WIDTH     updated membrane value
//  spk    out  1         threshold crossed this update
module lif_update_core
   import lif_pkg::*;
#(
   parameter int I_WIDTH      = LIF_I_WIDTH,
   parameter int I_FRAC_WIDTH = LIF_I_FRAC_WIDTH,
   parameter int WIDTH        = LIF_WIDTH,
   parameter int FRAC_WIDTH   = LIF_FRAC_WIDTH,
   parameter int A_OPT        = LIF_A_OPT,
   parameter int B_OPT        = LIF_B_OPT,
   parameter int V_RESET      = LIF_V_RESET
)(
   input  logic signed [WIDTH-1:0]   v,
   input  logic signed [I_WIDTH-1:0] cur,
   output logic signed [WIDTH-1:0]   v_next,
   output logic                      spk
);
   localparam int MW = 2 * WIDTH;
   localparam int SW = 2 * WIDTH + 2;
   localparam logic signed [MW-1:0] A_C = MW'(A_OPT);
   localparam logic signed [MW-1:0] B_C = MW'(B_OPT);
   localparam logic signed [SW-1:0] S_MAX = SW'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [SW-1:0] S_MIN = -S_MAX - 1;
   logic signed [MW-1:0] pd, pi;
   logic signed [SW-1:0] s;
   assign pd = MW'(v) * A_C;
   assign pi = B_C * MW'(cur);
   // extra headroom bits keep the sum exact before saturation
   assign s  = SW'(pd >>> FRAC_WIDTH) + SW'(pi >>> I_FRAC_WIDTH);
   always_comb begin
      spk    = s >= S_MAX;
      v_next = spk ? WIDTH'(V_RESET) : (s <= S_MIN) ? WIDTH'(S_MIN) : s[WIDTH-1:0];
   end
endmodule

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: time-multiplexes one LIF update core across N_NEURONS neurons
//  clk, rst    clock, synchronous active-high reset
//  step_valid  in   start request; step_ready out high in IDLE
//  cur_valid   in   current beat valid; cur_ready out high in RUN
//  cur_data    in   signed current for neuron cur_idx
//  cur_idx     out  neuron the next accepted beat updates
//  spikes      out  spike vector of last completed step
//  step_done   out  1-cycle pulse when spikes update
//  step_cnt    out  completed-step count (wraps)
//  Option: LIF_REFRACTORY_EN adds per-neuron refractory counters (REFRAC_STEPS)
module lif_tdm_scheduler
   import lif_pkg::*;
#(
   parameter int N_NEURONS    = LIF_N_NEURONS,
   parameter int I_WIDTH      = LIF_I_WIDTH,
   parameter int I_FRAC_WIDTH = LIF_I_FRAC_WIDTH,
   parameter int WIDTH        = LIF_WIDTH,
   parameter int FRAC_WIDTH   = LIF_FRAC_WIDTH,
   parameter int A_OPT        = LIF_A_OPT,
   parameter int B_OPT        = LIF_B_OPT,
   parameter int V_RESET      = LIF_V_RESET
`ifdef LIF_REFRACTORY_EN
   ,
   parameter int REFRAC_STEPS = 2
`endif
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           step_valid,
   output logic                           step_ready,
   input  logic                           cur_valid,
   output logic                           cur_ready,
   input  logic signed [I_WIDTH-1:0]      cur_data,
   output logic [$clog2(N_NEURONS)-1:0]   cur_idx,
   output logic [N_NEURONS-1:0]           spikes,
   output logic                           step_done,
   output logic [15:0]                    step_cnt
);
   localparam int IDX_W = $clog2(N_NEURONS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);
   fsm_e state;
   logic signed [WIDTH-1:0] v [N_NEURONS];
   logic [N_NEURONS-1:0] spike_buf;
   logic signed [WIDTH-1:0] v_core, v_new;
   logic spk_core, spk_new, accept;
   assign step_ready = state == IDLE;
   assign cur_ready  = state == RUN;
   assign accept     = cur_valid && cur_ready;
   lif_update_core #(
      .I_WIDTH(I_WIDTH), .I_FRAC_WIDTH(I_FRAC_WIDTH), .WIDTH(WIDTH), .FRAC_WIDTH(FRAC_WIDTH),
      .A_OPT(A_OPT), .B_OPT(B_OPT), .V_RESET(V_RESET)
   ) u_core (
      .v(v[cur_idx]), .cur(cur_data), .v_next(v_core), .spk(spk_core)
   );
`ifdef LIF_REFRACTORY_EN
   localparam int REF_W = $clog2(REFRAC_STEPS + 1);
   logic [REF_W-1:0] ref_cnt [N_NEURONS];
   logic hold;
   // a refractory neuron still consumes its beat but keeps its membrane value
   assign hold    = ref_cnt[cur_idx] != '0;
   assign v_new   = hold ? v[cur_idx] : v_core;
   assign spk_new = !hold && spk_core;
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < N_NEURONS; n++) ref_cnt[n] <= '0;
      end else if (accept) begin
         ref_cnt[cur_idx] <= spk_new ? REF_W'(REFRAC_STEPS) : hold ? ref_cnt[cur_idx] - 1'b1 : ref_cnt[cur_idx];
      end
   end
`else
   assign v_new   = v_core;
   assign spk_new = spk_core;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_idx   <= '0;
         spikes    <= '0;
         spike_buf <= '0;
         step_done <= 1'b0;
         step_cnt  <= '0;
         for (int n = 0; n < N_NEURONS; n++) v[n] <= '0;
      end else begin
         step_done <= 1'b0;
         if (state == IDLE && step_valid) state <= RUN;
         if (accept) begin
            v[cur_idx]         <= v_new;
            spike_buf[cur_idx] <= spk_new;
            cur_idx            <= cur_idx + 1'b1;
            if (cur_idx == LAST) state <= DONE;
         end
         if (state == DONE) begin
            spikes    <= spike_buf;
            step_done <= 1'b1;
            step_cnt  <= step_cnt + 1'b1;
            cur_idx   <= '0;
            state     <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb_lif_tdm_scheduler: directed checks of lif_tdm_scheduler (N=4; instance b uses B_OPT=4096)
module tb_lif_tdm_scheduler;
   import lif_pkg::*;
   logic clk = 1'b0;
   logic rst [2];
   logic step_valid [2];
   logic cur_valid [2];
   logic [7:0] cur_data [2];
   logic step_ready [2];
   logic cur_ready [2];
   logic step_done [2];
   logic [1:0] cur_idx [2];
   logic [3:0] spikes [2];
   logic [15:0] step_cnt [2];
   int n_cmp = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   lif_tdm_scheduler #(.N_NEURONS(4)) u_a (
      .clk(clk), .rst(rst[0]), .step_valid(step_valid[0]), .step_ready(step_ready[0]),
      .cur_valid(cur_valid[0]), .cur_ready(cur_ready[0]), .cur_data(cur_data[0]),
      .cur_idx(cur_idx[0]), .spikes(spikes[0]), .step_done(step_done[0]), .step_cnt(step_cnt[0])
   );
   lif_tdm_scheduler #(.N_NEURONS(4), .B_OPT(4096)) u_b (
      .clk(clk), .rst(rst[1]), .step_valid(step_valid[1]), .step_ready(step_ready[1]),
      .cur_valid(cur_valid[1]), .cur_ready(cur_ready[1]), .cur_data(cur_data[1]),
      .cur_idx(cur_idx[1]), .spikes(spikes[1]), .step_done(step_done[1]), .step_cnt(step_cnt[1])
   );
   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic int v_of(input int k, input int i);
      state_t x;
      x = k != 0 ? u_b.v[i] : u_a.v[i];
      return int'(x);
   endfunction
   task automatic check_v(input int k, input int e0, input int e1, input int e2, input int e3);
      int e [4];
      e = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++) check($sformatf("v%0d_%0d", k, i), v_of(k, i), e[i]);
   endtask
   task automatic run_step(input int k, input logic [31:0] cur, input bit gap, input logic [3:0] exp_spk);
      int n;
      n = 0;
      while (!step_ready[k] && n < 10) begin
         @(posedge clk); #1; n++;
      end
      check("step_ready_idle", int'(step_ready[k]), 1);
      step_valid[k] = 1'b1;
      @(posedge clk); #1;
      step_valid[k] = 1'b0;
      check("cur_ready_run", int'(cur_ready[k]), 1);
      for (int i = 0; i < 4; i++) begin
         if (gap) begin
            cur_valid[k]  = 1'b0;
            step_valid[k] = 1'b1;
            @(posedge clk); #1;
            step_valid[k] = 1'b0;
            check("stall_idx", int'(cur_idx[k]), i);
            check("busy_ready", int'(step_ready[k]), 0);
         end
         check("cur_idx", int'(cur_idx[k]), i);
         cur_valid[k] = 1'b1;
         cur_data[k]  = cur[8*i +: 8];
         @(posedge clk); #1;
      end
      cur_valid[k] = 1'b0;
      check("done_early", int'(step_done[k]), 0);
      n = 0;
      while (!step_done[k] && n < 4) begin
         @(posedge clk); #1; n++;
      end
      check("done_lat", n, 1);
      check("spikes", int'(spikes[k]), int'(exp_spk));
      @(posedge clk); #1;
      check("done_pulse", int'(step_done[k]), 0);
   endtask
   initial begin
      int n;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; step_valid[k] = 1'b0; cur_valid[k] = 1'b0; cur_data[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      check("rst_spikes", int'(spikes[0]), 0);
      check("rst_done", int'(step_done[0]), 0);
      check("rst_cnt", int'(step_cnt[0]), 0);
      check("rst_idx", int'(cur_idx[0]), 0);
      check("rst_step_ready", int'(step_ready[0]), 1);
      check("rst_cur_ready", int'(cur_ready[0]), 0);
      check_v(0, 0, 0, 0, 0);
      run_step(0, 32'h10101010, 1'b0, 4'h0);
      check_v(0, 256, 256, 256, 256);
      check("cnt1", int'(step_cnt[0]), 1);
      run_step(0, 32'h00000000, 1'b1, 4'h0);
      check_v(0, 232, 232, 232, 232);
      check("cnt2", int'(step_cnt[0]), 2);
      step_valid[0] = 1'b1;
      @(posedge clk); #1;
      step_valid[0] = 1'b0;
      cur_valid[0] = 1'b1;
      cur_data[0]  = 8'h10;
      repeat (2) @(posedge clk);
      #1;
      cur_valid[0] = 1'b0;
      rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      n = 0;
      repeat (4) begin
         if (step_done[0]) n++;
         @(posedge clk); #1;
      end
      check("rst_mid_no_done", n, 0);
      check_v(0, 0, 0, 0, 0);
      check("rst_mid_cnt", int'(step_cnt[0]), 0);
      check("rst_mid_idx", int'(cur_idx[0]), 0);
      check("rst_mid_ready", int'(step_ready[0]), 1);
      run_step(1, 32'h7F7F7F7F, 1'b0, 4'h0);
      check_v(1, 32512, 32512, 32512, 32512);
      run_step(1, 32'h7F7F7F7F, 1'b0, 4'hF);
      check_v(1, LIF_V_RESET, LIF_V_RESET, LIF_V_RESET, LIF_V_RESET);
`ifdef LIF_REFRACTORY_EN
      run_step(1, 32'h7F7F7F7F, 1'b0, 4'h0);
      check_v(1, -20480, -20480, -20480, -20480);
      run_step(1, 32'h7F7F7F7F, 1'b0, 4'h0);
      check_v(1, -20480, -20480, -20480, -20480);
      run_step(1, 32'h7F7F7F7F, 1'b0, 4'h0);
      check_v(1, 13952, 13952, 13952, 13952);
`else
      run_step(1, 32'h00800000, 1'b0, 4'h0);
      check_v(1, -18560, -18560, MIN_VAL, -18560);
      run_step(1, 32'h00000000, 1'b0, 4'h0);
      check_v(1, -16820, -16820, -29696, -16820);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
